vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameters: H_DISP 640 (visible pixels per line); H_FP 16 (front-porch pixels); H_SW 96 (hsync width in pixels); H_BP 48 (back-porch pixels); V_DISP 480 (visible lines); V_FP 10 (front-porch lines); V_SW 2 (vsync width in lines); V_BP 33 (back-porch lines); DIV 2 (clk cycles per pixel, DIV>=1); HS_POL 1 (1 = hsync active-high); VS_POL 1 (1 = vsync active-high); CW 10 (pixel_x/pixel_y width); FW 8 (frame counter width).
REQ-002 clk  in  1  system clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  run enable.
REQ-005 restart  in  1  synchronous restart to position (0,0).
REQ-006 hsync  out  1  horizontal sync at HS_POL polarity.
REQ-007 vsync  out  1  vertical sync at VS_POL polarity.
REQ-008 video_on  out  1  high while the current position is in the visible area.
REQ-009 p_tick  out  1  one-clk pixel strobe.
REQ-010 pixel_x  out  CW  current horizontal count.
REQ-011 pixel_y  out  CW  current vertical count.
REQ-012 sol  out  1  start-of-line pulse.
REQ-013 sof  out  1  start-of-frame pulse.
REQ-014 frame_cnt  out  FW  count of completed frames.

Function
REQ-015 The divider SHALL count 0..DIV-1 while en=1 and generate a tick when it equals DIV-1; for DIV=1 the tick SHALL be high on every enabled clk.
REQ-016 On a tick, h_cnt SHALL increment, wrapping from H_TOT-1 to 0, where H_TOT = H_DISP+H_FP+H_SW+H_BP.
REQ-017 On a tick with h_cnt=H_TOT-1, v_cnt SHALL increment, wrapping from V_TOT-1 to 0, where V_TOT = V_DISP+V_FP+V_SW+V_BP.
REQ-018 On a tick that wraps both counters, frame_cnt SHALL increment modulo 2^FW.
REQ-019 Horizontal line order SHALL be display, front porch, sync, back porch.
REQ-020 hsync SHALL be active for H_DISP+H_FP <= h_cnt <= H_DISP+H_FP+H_SW-1; vsync SHALL be active for V_DISP+V_FP <= v_cnt <= V_DISP+V_FP+V_SW-1.
REQ-021 video_on SHALL be (h_cnt<H_DISP) && (v_cnt<V_DISP).
REQ-022 sol SHALL be high while h_cnt=0 and the tick is high.
REQ-023 sof SHALL be high while h_cnt=0, v_cnt=0 and the tick is high.
REQ-024 hsync, vsync, video_on, p_tick, sol, sof, pixel_x and pixel_y SHALL all be registered from the same counter/divider state, so they are mutually consistent and lag the internal state by exactly 1 clk.
REQ-025 When en=0, the divider and counters SHALL hold; p_tick, sol, sof and video_on SHALL be 0; hsync and vsync SHALL be inactive.
REQ-026 When en rises, counting SHALL resume from the held position.
REQ-027 restart=1 SHALL clear the divider, h_cnt, v_cnt and frame_cnt on the next clk edge, with priority over en and the tick.
REQ-028 The first tick after restart SHALL occur DIV clks later.
REQ-029 pixel_x and pixel_y SHALL be the counters zero-extended or truncated to CW bits; H_TOT and V_TOT SHALL each be at most 2^CW, which is a parameter-legality rule.

Reset
REQ-030 While reset=0, the divider, counters, frame_cnt, p_tick, sol, sof, video_on, pixel_x and pixel_y SHALL be 0, and hsync/vsync SHALL be at their inactive levels (~HS_POL, ~VS_POL).
REQ-031 Reset asserted mid-frame SHALL take effect immediately (asynchronously); the first tick after release SHALL occur DIV clks after the first enabled edge.

Structure
REQ-032 A shared package vga_pkg SHALL hold the default timing constants (640x480@60 set) and a timing-record typedef, for reuse by pixel generators.
REQ-033 One sub-module, vga_axis_counter, SHALL be instantiated twice (horizontal, vertical); it is parametrised by DISP/FP/SW/BP/POL and produces count, wrap, sync-active and in-display signals.

Verification
REQ-034 Defaults, en=1, 2 frames: p_tick every 2nd clk; hsync high exactly 96 ticks per line starting at pixel_x=656; 800 ticks per line; 525 lines per frame; frame_cnt goes 0->1->2.
REQ-035 Defaults: vsync high only for pixel_y 490..491; video_on high for exactly 640x480 ticks per frame; sof occurs once per 420000 ticks.
REQ-036 DIV=1, HS_POL=0, VS_POL=0, small timing (8/1/2/1 by 4/1/1/1): p_tick constant 1; hsync low for pixel_x 9..10; full frame every 84 clks.
REQ-037 en dropped at pixel_x=100 for 50 clks: outputs held, video_on=0, syncs inactive; on resume the next tick shows pixel_x=101.
REQ-038 restart asserted at (700,300) coincident with a tick: next state is (0,0) with frame_cnt=0; the first sof arrives DIV clks later.
REQ-039 reset pulsed low mid-line: all outputs immediately take REQ-030 values; after release the counting sequence matches a cold start.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants and timing record types
package vga_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int H_DISP_DEF = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SW_DEF   = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_DISP_DEF = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SW_DEF   = 2;
    localparam int V_BP_DEF   = 33;

    typedef struct packed {
        logic [11:0] disp;
        logic [11:0] fp;
        logic [11:0] sw;
        logic [11:0] bp;
    } vga_axis_timing_t;

    typedef struct packed {
        vga_axis_timing_t h;
        vga_axis_timing_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h: '{disp: 12'd640, fp: 12'd16, sw: 12'd96, bp: 12'd48},
        v: '{disp: 12'd480, fp: 12'd10, sw: 12'd2,  bp: 12'd33}
    };

    function automatic int axis_total(input vga_axis_timing_t t);
        return int'(t.disp) + int'(t.fp) + int'(t.sw) + int'(t.bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter, wrap, sync and display decode
module vga_axis_counter #(
    parameter int DISP = 640,
    parameter int FP   = 16,
    parameter int SW   = 96,
    parameter int BP   = 48,
    parameter int POL  = 1,
    parameter int W    = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         step,
    input  logic         active,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync,
    output logic         in_disp
);

    localparam int TOT = DISP + FP + SW + BP;
    localparam logic [W-1:0] LAST       = W'(TOT - 1);
    localparam logic [W-1:0] SYNC_FIRST = W'(DISP + FP);
    localparam logic [W-1:0] SYNC_LAST  = W'(DISP + FP + SW - 1);
    localparam logic [W-1:0] DISP_END   = W'(DISP);
    localparam logic         SYNC_ON    = (POL != 0);

    logic sync_act;

    assign wrap     = (count == LAST);
    assign sync_act = (count >= SYNC_FIRST) && (count <= SYNC_LAST);
    assign in_disp  = (count < DISP_END);
    // An idle generator always presents the inactive sync level.
    assign sync     = (active && sync_act) ? SYNC_ON : ~SYNC_ON;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (step) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel divider and frame counter
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SW   = H_SW_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_DISP = V_DISP_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SW   = V_SW_DEF,
    parameter int V_BP   = V_BP_DEF,
    parameter int DIV    = 2,
    parameter int HS_POL = 1,
    parameter int VS_POL = 1,
    parameter int CW     = 10,
    parameter int FW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          restart,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          p_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          sol,
    output logic          sof,
    output logic [FW-1:0] frame_cnt
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic HS_OFF = (HS_POL == 0);
    localparam logic VS_OFF = (VS_POL == 0);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_sync;
    logic          v_sync;
    logic          h_in_disp;
    logic          v_in_disp;
    logic          v_step;

    // With DIV=1 the divider is pinned at zero, so tick follows en.
    assign tick   = en && (div_cnt == DIV_LAST);
    assign v_step = tick && h_wrap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (restart) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
        end
    end

    vga_axis_counter #(
        .DISP (H_DISP),
        .FP   (H_FP),
        .SW   (H_SW),
        .BP   (H_BP),
        .POL  (HS_POL),
        .W    (CW)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .clr     (restart),
        .step    (tick),
        .active  (en),
        .count   (h_count),
        .wrap    (h_wrap),
        .sync    (h_sync),
        .in_disp (h_in_disp)
    );

    vga_axis_counter #(
        .DISP (V_DISP),
        .FP   (V_FP),
        .SW   (V_SW),
        .BP   (V_BP),
        .POL  (VS_POL),
        .W    (CW)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .clr     (restart),
        .step    (v_step),
        .active  (en),
        .count   (v_count),
        .wrap    (v_wrap),
        .sync    (v_sync),
        .in_disp (v_in_disp)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (restart) begin
            frame_cnt <= '0;
        end else if (v_step && v_wrap) begin
            frame_cnt <= frame_cnt + FW'(1);
        end
    end

    // Every raster output is sampled from the same pre-update state,
    // so they stay mutually aligned one clk behind the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_tick   <= 1'b0;
            sol      <= 1'b0;
            sof      <= 1'b0;
            video_on <= 1'b0;
            hsync    <= HS_OFF;
            vsync    <= VS_OFF;
            pixel_x  <= '0;
            pixel_y  <= '0;
        end else begin
            p_tick   <= tick;
            sol      <= tick && (h_count == '0);
            sof      <= tick && (h_count == '0) && (v_count == '0);
            video_on <= en && h_in_disp && v_in_disp;
            hsync    <= h_sync;
            vsync    <= v_sync;
            pixel_x  <= h_count;
            pixel_y  <= v_count;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_en, a_restart;
    logic       a_hsync, a_vsync, a_video_on, a_p_tick, a_sol, a_sof;
    logic [9:0] a_pixel_x, a_pixel_y;
    logic [7:0] a_frame_cnt;

    logic       b_reset, b_en, b_restart;
    logic       b_hsync, b_vsync, b_video_on, b_p_tick, b_sol, b_sof;
    logic [9:0] b_pixel_x, b_pixel_y;
    logic [7:0] b_frame_cnt;

    vga_timing_gen dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .en        (a_en),
        .restart   (a_restart),
        .hsync     (a_hsync),
        .vsync     (a_vsync),
        .video_on  (a_video_on),
        .p_tick    (a_p_tick),
        .pixel_x   (a_pixel_x),
        .pixel_y   (a_pixel_y),
        .sol       (a_sol),
        .sof       (a_sof),
        .frame_cnt (a_frame_cnt)
    );

    vga_timing_gen #(
        .H_DISP (8), .H_FP (1), .H_SW (2), .H_BP (1),
        .V_DISP (4), .V_FP (1), .V_SW (1), .V_BP (1),
        .DIV (1), .HS_POL (0), .VS_POL (0), .CW (10), .FW (8)
    ) dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .en        (b_en),
        .restart   (b_restart),
        .hsync     (b_hsync),
        .vsync     (b_vsync),
        .video_on  (b_video_on),
        .p_tick    (b_p_tick),
        .pixel_x   (b_pixel_x),
        .pixel_y   (b_pixel_y),
        .sol       (b_sol),
        .sof       (b_sof),
        .frame_cnt (b_frame_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int ticks, hs, hs_first, vid, sols, sofs, ptick_err, px_err;
        int held_tick, held_vid, held_sync, lat, found;
        int hlow, hbad, vlow, vbad, last_sof, gap_bad;

        a_reset = 1'b0; a_en = 1'b0; a_restart = 1'b0;
        b_reset = 1'b0; b_en = 1'b0; b_restart = 1'b0;
        repeat (3) @(negedge clk);

        check("a_rst_ptick", a_p_tick, 0);
        check("a_rst_px", a_pixel_x, 0);
        check("a_rst_hsync", a_hsync, 0);
        check("a_rst_vsync", a_vsync, 0);
        check("a_rst_video", a_video_on, 0);
        check("a_rst_sof", a_sof, 0);
        check("a_rst_frame", a_frame_cnt, 0);
        check("b_rst_hsync", b_hsync, 1);
        check("b_rst_vsync", b_vsync, 1);

        // default timing, DIV=2: one full line
        a_reset = 1'b1; a_en = 1'b1;
        ticks = 0; hs = 0; hs_first = -1; vid = 0; sols = 0; sofs = 0; ptick_err = 0; px_err = 0;
        for (int i = 1; i <= 1600; i++) begin
            nxt();
            if (a_p_tick !== ((i % 2) == 0)) ptick_err++;
            if (a_p_tick) begin
                ticks++;
                if (a_pixel_x !== 10'(i / 2 - 1)) px_err++;
                if (a_hsync) begin
                    hs++;
                    if (hs_first < 0) hs_first = int'(a_pixel_x);
                end
                if (a_video_on) vid++;
                if (a_sol) sols++;
                if (a_sof) sofs++;
            end
        end
        check("a_ptick_pattern", ptick_err, 0);
        check("a_ticks_per_line", ticks, 800);
        check("a_px_sequence", px_err, 0);
        check("a_hsync_ticks", hs, 96);
        check("a_hsync_first_x", hs_first, 656);
        check("a_video_ticks", vid, 640);
        check("a_sol_count", sols, 1);
        check("a_sof_count", sofs, 1);
        nxt();
        check("a_line1_px", a_pixel_x, 0);
        check("a_line1_py", a_pixel_y, 1);

        // drop en right after the tick at pixel_x=100
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            nxt();
            if (a_p_tick && a_pixel_x == 10'd100) found = 1;
        end
        check("a_find_x100", found, 1);
        a_en = 1'b0;
        held_tick = 0; held_vid = 0; held_sync = 0; px_err = 0;
        for (int i = 0; i < 50; i++) begin
            nxt();
            if (a_p_tick || a_sol || a_sof) held_tick++;
            if (a_video_on) held_vid++;
            if (a_hsync || a_vsync) held_sync++;
            if (a_pixel_x !== 10'd101 || a_pixel_y !== 10'd1) px_err++;
        end
        check("a_hold_tick", held_tick, 0);
        check("a_hold_video", held_vid, 0);
        check("a_hold_sync", held_sync, 0);
        check("a_hold_pos", px_err, 0);
        a_en = 1'b1;
        lat = 0; found = 0;
        for (int i = 1; i <= 10 && found == 0; i++) begin
            nxt();
            if (a_p_tick) begin found = 1; lat = i; end
        end
        check("a_resume_latency", lat, 2);
        check("a_resume_px", a_pixel_x, 101);

        // asynchronous reset while hsync is active
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            nxt();
            if (a_hsync) found = 1;
        end
        check("a_find_hsync", found, 1);
        #2 a_reset = 1'b0;
        #1;
        check("a_async_hsync", a_hsync, 0);
        check("a_async_px", a_pixel_x, 0);
        check("a_async_py", a_pixel_y, 0);
        check("a_async_video", a_video_on, 0);
        check("a_async_ptick", a_p_tick, 0);
        @(negedge clk);
        a_reset = 1'b1;
        nxt();
        check("a_cold_ptick0", a_p_tick, 0);
        check("a_cold_video0", a_video_on, 1);
        nxt();
        check("a_cold_ptick1", a_p_tick, 1);
        check("a_cold_sof", a_sof, 1);

        // restart coincident with the tick at pixel_x=700
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            nxt();
            if (a_p_tick && a_pixel_x == 10'd699) found = 1;
        end
        check("a_find_x699", found, 1);
        nxt();
        a_restart = 1'b1;
        nxt();
        check("a_restart_tick", a_p_tick, 1);
        check("a_restart_prex", a_pixel_x, 700);
        a_restart = 1'b0;
        nxt();
        check("a_restart_px", a_pixel_x, 0);
        check("a_restart_ptick", a_p_tick, 0);
        nxt();
        check("a_restart_sof", a_sof, 1);

        // small timing, DIV=1, active-low syncs: two frames
        b_reset = 1'b1; b_en = 1'b1;
        ptick_err = 0; hlow = 0; hbad = 0; vlow = 0; vbad = 0; vid = 0;
        sols = 0; sofs = 0; last_sof = -1; gap_bad = 0;
        for (int i = 1; i <= 168; i++) begin
            nxt();
            if (!b_p_tick) ptick_err++;
            if (!b_hsync) begin
                hlow++;
                if (b_pixel_x < 10'd9 || b_pixel_x > 10'd10) hbad++;
            end
            if (!b_vsync) begin
                vlow++;
                if (b_pixel_y !== 10'd5) vbad++;
            end
            if (b_video_on) vid++;
            if (b_sol) sols++;
            if (b_sof) begin
                sofs++;
                if (last_sof >= 0 && i - last_sof != 84) gap_bad++;
                last_sof = i;
            end
            if (i == 1) check("b_first_sof", b_sof, 1);
            if (i == 83) check("b_frame_at83", b_frame_cnt, 0);
            if (i == 84) check("b_frame_at84", b_frame_cnt, 1);
            if (i == 168) check("b_frame_at168", b_frame_cnt, 2);
        end
        check("b_ptick_const", ptick_err, 0);
        check("b_hsync_low", hlow, 28);
        check("b_hsync_pos", hbad, 0);
        check("b_vsync_low", vlow, 24);
        check("b_vsync_pos", vbad, 0);
        check("b_video", vid, 64);
        check("b_sol", sols, 14);
        check("b_sof", sofs, 2);
        check("b_sof_gap", gap_bad, 0);

        b_restart = 1'b1;
        nxt();
        check("b_restart_frame", b_frame_cnt, 0);
        b_restart = 1'b0;
        nxt();
        check("b_restart_sof", b_sof, 1);
        check("b_restart_px", b_pixel_x, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
